seq_detector_mealy_param: RTL and testbench



---
 rtl/seq_detector_mealy_param.sv | 153 +++++++++++++++
 tb/tb_seq_detector_mealy_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_detector_mealy_param.sv
`default_nettype none
// ============================================================================
// Module   : seq_detector_mealy_param
// Purpose  : Parametrised Mealy serial pattern detector. Watches a 1-bit
//            stream (sampled only when en=1) and raises z combinationally in
//            the cycle the last bit of an N-bit PATTERN arrives. Supports
//            overlapping or non-overlapping matching and keeps a saturating
//            match counter.
// Ports    : clk          - system clock, rising edge
//            reset        - asynchronous active-low reset
//            en           - sample strobe, w consumed only when en=1
//            w            - serial data bit
//            clear        - synchronous clear of match_count only
//            z            - Mealy match output (same cycle as final bit)
//            match_count  - saturating number of matches since reset/clear
//            progress     - current matched-prefix length (0..N-1)
//            z_q          - z registered one clk later (SEQ_DET_REGOUT_EN)
// Options  : define SEQ_DET_REGOUT_EN to add the registered z_q output.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detector_mealy_param #(
    parameter int             N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int             CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic                 w,
    input  logic                 clear,
    output logic                 z,
    output logic [CNT_W-1:0]     match_count,
    output logic [$clog2(N)-1:0] progress
`ifdef SEQ_DET_REGOUT_EN
    ,
    output logic                 z_q
`endif
);

    localparam int                c_prog_w  = $clog2(N);
    localparam logic [c_prog_w-1:0] c_s_idle = '0;
    localparam logic [c_prog_w-1:0] c_s_last = c_prog_w'(N - 1);
    localparam logic [CNT_W-1:0]  c_cnt_max = {CNT_W{1'b1}};

    generate
        if ((N < 2) || (N > 16)) begin : g_bad_n
            $error("seq_detector_mealy_param: N must be in 2..16");
        end
    endgenerate

    // Next prefix length after accepting bit b in state s: the longest k
    // (capped at N-1, so a full match folds onto its border) such that the
    // last k bits of "PATTERN prefix of length s, then b" equal the first k
    // pattern bits. Evaluated only with constant arguments at elaboration.
    function automatic int kmp_next(input int s, input bit b);
        logic [15:0] seq;
        int          best;
        bit          ok;
        best = 0;
        seq  = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < s) begin
                seq[i] = PATTERN[N-1-i];
            end else if (i == s) begin
                seq[i] = b;
            end
        end
        for (int k = 1; k < 16; k++) begin
            if ((k <= s + 1) && (k <= N - 1)) begin
                ok = 1'b1;
                for (int j = 0; j < 16; j++) begin
                    if ((j < k) && (seq[s+1-k+j] != PATTERN[N-1-j])) begin
                        ok = 1'b0;
                    end
                end
                if (ok) begin
                    best = k;
                end
            end
        end
        return best;
    endfunction

    logic [c_prog_w-1:0] state_q;
    logic [c_prog_w-1:0] state_d;
    logic [CNT_W-1:0]    count_q;
    logic [CNT_W-1:0]    count_d;

    logic [c_prog_w-1:0] w_next_tbl [N][2];
    logic                w_exp_tbl  [N];
    logic                w_exp_bit;

    generate
        for (genvar gs = 0; gs < N; gs++) begin : g_state
            assign w_exp_tbl[gs] = PATTERN[N-1-gs];
            for (genvar gb = 0; gb < 2; gb++) begin : g_bit
                assign w_next_tbl[gs][gb] = c_prog_w'(kmp_next(gs, (gb != 0)));
            end
        end
    endgenerate

    assign w_exp_bit = w_exp_tbl[state_q];

    // Gated by reset so z is forced low for the whole reset assertion.
    assign z = reset & en & (state_q == c_s_last) & (w == w_exp_bit);

    always_comb begin
        state_d = state_q;
        if (en) begin
            if (z && !OVERLAP) begin
                state_d = c_s_idle;
            end else begin
                // On a match the table already yields the pattern's border.
                state_d = w_next_tbl[state_q][w];
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (z && (count_q != c_cnt_max)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= c_s_idle;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

`ifdef SEQ_DET_REGOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            z_q <= 1'b0;
        end else begin
            z_q <= z;
        end
    end
`endif

    assign progress    = state_q;
    assign match_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_mealy_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detector_mealy_param
// Purpose  : Self-checking bench for seq_detector_mealy_param. Three DUTs
//            share one stimulus stream: overlapping (A), non-overlapping (B)
//            and overlapping with a 2-bit counter (C). A reference model
//            derived directly from the matching definition (history of
//            accepted bits) pushes expectations to a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detector_mealy_param;

    localparam int         N   = 4;
    localparam logic [3:0] PAT = 4'b1011;

    logic clk = 1'b0;
    logic reset, en, w, clear;
    logic       za, zb, zc;
    logic [7:0] ca, cb;
    logic [1:0] cc;
    logic [1:0] pa, pb, pc;
`ifdef SEQ_DET_REGOUT_EN
    logic zqa, zqb, zqc;
`endif

    always #5 clk = ~clk;

    seq_detector_mealy_param #(.N(N), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(8)) dut_a (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .z(za), .match_count(ca), .progress(pa)
`ifdef SEQ_DET_REGOUT_EN
        , .z_q(zqa)
`endif
    );

    seq_detector_mealy_param #(.N(N), .PATTERN(PAT), .OVERLAP(1'b0), .CNT_W(8)) dut_b (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .z(zb), .match_count(cb), .progress(pb)
`ifdef SEQ_DET_REGOUT_EN
        , .z_q(zqb)
`endif
    );

    seq_detector_mealy_param #(.N(N), .PATTERN(PAT), .OVERLAP(1'b1), .CNT_W(2)) dut_c (
        .clk(clk), .reset(reset), .en(en), .w(w), .clear(clear),
        .z(zc), .match_count(cc), .progress(pc)
`ifdef SEQ_DET_REGOUT_EN
        , .z_q(zqc)
`endif
    );

    // ---------------- reference model ----------------
    int          ovl  [3] = '{1, 0, 1};
    int          cmax [3] = '{255, 255, 3};
    logic [31:0] hist [3];
    int          hlen [3];
    int          cnt  [3];
    logic        zq_exp [3];

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_q [$];

    function automatic logic mz(input int i, input logic e, input logic b, input logic r);
        if (!r || !e || (hlen[i] + 1 < N)) return 1'b0;
        return ((((hist[i] << 1) | 32'(b)) & 32'hF) == 32'(PAT));
    endfunction

    function automatic int mprog(input int i);
        for (int k = N - 1; k >= 1; k--) begin
            if ((k <= hlen[i]) &&
                ((hist[i] & ((32'd1 << k) - 32'd1)) == (32'(PAT) >> (N - k))))
                return k;
        end
        return 0;
    endfunction

    task automatic model_edge(input logic e, input logic b, input logic c);
        logic zz;
        for (int i = 0; i < 3; i++) begin
            zz = mz(i, e, b, reset);
            zq_exp[i] = zz;
            if (e) begin
                hist[i] = (hist[i] << 1) | 32'(b);
                hlen[i] = hlen[i] + 1;
                if (zz && (ovl[i] == 0)) hlen[i] = 0;
            end
            if (c) cnt[i] = 0;
            else if (zz && (cnt[i] < cmax[i])) cnt[i] = cnt[i] + 1;
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            hist[i] = '0; hlen[i] = 0; cnt[i] = 0; zq_exp[i] = 1'b0;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs);
        logic [31:0] expv;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, observed=%0h", tag, obs);
        end else begin
            expv = exp_q.pop_front();
            assert (obs === expv) else begin
                miscompares++;
                $error("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, expv, $time);
            end
        end
    endtask

    task automatic check_state();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(mprog(i)));
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(cnt[i]));
        check("progress_a", 32'(pa));
        check("progress_b", 32'(pb));
        check("progress_c", 32'(pc));
        check("count_a", 32'(ca));
        check("count_b", 32'(cb));
        check("count_c", 32'(cc));
`ifdef SEQ_DET_REGOUT_EN
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(zq_exp[i]));
        check("zq_a", 32'(zqa));
        check("zq_b", 32'(zqb));
        check("zq_c", 32'(zqc));
`endif
    endtask

    // One sampled bit: drive at negedge, check Mealy z before the edge,
    // check registered state just after the edge.
    task automatic step(input logic e, input logic b, input logic c);
        @(negedge clk);
        en = e; w = b; clear = c;
        #1;
        for (int i = 0; i < 3; i++) exp_q.push_back(32'(mz(i, e, b, reset)));
        check("z_a", 32'(za));
        check("z_b", 32'(zb));
        check("z_c", 32'(zc));
        @(posedge clk);
        model_edge(e, b, c);
        #1;
        check_state();
    endtask

    task automatic feed(input logic [31:0] bits, input int len);
        for (int k = len - 1; k >= 0; k--) step(1'b1, bits[k], 1'b0);
    endtask

    // Asynchronous reset applied wherever the caller happens to be in time;
    // en/w are held high to show z stays low, then en drops before release.
    task automatic reset_now();
        reset = 1'b0; en = 1'b1; w = 1'b1; clear = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) exp_q.push_back(32'd0);
        check("z_a_rst", 32'(za));
        check("z_b_rst", 32'(zb));
        check("z_c_rst", 32'(zc));
        check_state();
        @(negedge clk);
        en = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; en = 1'b0; w = 1'b0; clear = 1'b0;
        #2;
        reset_now();

        // Overlap vs non-overlap on 1,0,1,1,0,1,1
        feed(32'b1011011, 7);

        // en=0 pause mid-pattern with w toggling, then the final bit
        reset_now();
        feed(32'b101, 3);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0);

        // Counter saturation on back-to-back patterns, then clear vs match
        reset_now();
        for (int r = 0; r < 5; r++) feed(32'b1011, 4);
        feed(32'b101, 3);
        step(1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0);

        // Reset mid-pattern, away from the clock edge
        reset_now();
        feed(32'b101, 3);
        #2;
        reset_now();
        feed(32'b1011, 4);

        // Random stream with sparse enables and clears
        for (int r = 0; r < 60; r++)
            step(($urandom % 4) != 0, $urandom % 2, ($urandom % 16) == 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
